// File: rtl/mxm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mxm_pkg
//  Purpose  : Shared types, mode constants and nibble decoder for the
//             mxm_tile_engine outer-product matrix engine.
//  Revision : 1.0
// ============================================================================
package mxm_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic MODE_I4  = 1'b0;
    localparam logic MODE_FP4 = 1'b1;
    localparam int   PROD_W   = 9;

    // fp4 e2m1 is returned scaled by 2 so every value is an exact integer.
    function automatic logic signed [4:0] dec4(input logic mode, input logic [3:0] nib);
        logic [4:0] mag;
        logic signed [4:0] res;
        case (nib[2:1])
            2'd0:    mag = {4'b0000, nib[0]};
            2'd1:    mag = {3'b000, 1'b1, nib[0]};
            2'd2:    mag = {2'b00, 1'b1, nib[0], 1'b0};
            default: mag = {1'b0, 1'b1, nib[0], 2'b00};
        endcase
        if (mode == MODE_I4) begin
            res = $signed({nib[3], nib});
        end else if (nib[3]) begin
            res = $signed(-mag);
        end else begin
            res = $signed(mag);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mxm_sat_mac.sv
`default_nettype none
// ============================================================================
//  Module   : mxm_sat_mac
//  Purpose  : One saturating accumulator cell: acc += prod with clamp flag.
//  Revision : 1.0
// ============================================================================
module mxm_sat_mac
    import mxm_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [PROD_W-1:0] prod_i,
    output logic        [ACC_W-1:0]  acc_o,
    output logic                     clamp_o
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_pos_ovf;
    logic                    w_neg_ovf;

    // One guard bit is enough: |prod| <= 144 is far below half the range.
    assign w_sum     = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(prod_i);
    assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
    assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];

    always_comb begin
        acc_d = w_sum[ACC_W-1:0];
        if (w_pos_ovf) begin
            acc_d = ACC_MAX;
        end else if (w_neg_ovf) begin
            acc_d = ACC_MIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o   = acc_q;
    assign clamp_o = en_i & (w_pos_ovf | w_neg_ovf);

endmodule
`default_nettype wire

// File: rtl/mxm_tile_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mxm_tile_engine
//  Purpose  : Streaming NxN outer-product engine accumulating C = A*B over K
//             in int4 or fp4 (e2m1) mode, draining results row-major.
//  Revision : 1.0
// ============================================================================
module mxm_tile_engine
    import mxm_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last,
    output logic             ovf
);

    localparam int NN     = N * N;
    localparam int IDX_W  = $clog2(N);
    localparam int OIDX_W = $clog2(NN);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(N - 1);
    localparam logic [OIDX_W-1:0] LAST_OUT  = OIDX_W'(NN - 1);
    localparam logic [OIDX_W-1:0] PENULT    = OIDX_W'(NN - 2);

    state_e              state_q;
    logic [IDX_W-1:0]    bidx_q;
    logic [OIDX_W-1:0]   oidx_q;
    logic [3:0]          a_q [N];
    logic [3:0]          b_q [N];
    logic                mode_q;
    logic                first_q;
    logic                last_q;
    logic                ovf_q;
    logic                out_valid_q;
    logic                out_last_q;

    logic signed [PROD_W-1:0] w_a_ext [N];
    logic signed [PROD_W-1:0] w_b_ext [N];
    logic [ACC_W-1:0]         w_acc   [NN];
    logic [NN-1:0]            w_clamp;
    logic                     w_mac_en;
    logic                     w_clr;

    assign in_ready = (state_q == LOAD);
    assign w_mac_en = (state_q == MAC);
    assign w_clr    = (state_q == DRAIN) && out_ready && (oidx_q == LAST_OUT);

    generate
        for (genvar g = 0; g < N; g++) begin : g_dec
            assign w_a_ext[g] = PROD_W'(dec4(mode_q, a_q[g]));
            assign w_b_ext[g] = PROD_W'(dec4(mode_q, b_q[g]));
        end
        for (genvar r = 0; r < N; r++) begin : g_row
            for (genvar c = 0; c < N; c++) begin : g_col
                logic signed [PROD_W-1:0] w_prod;
                assign w_prod = w_a_ext[r] * w_b_ext[c];
                mxm_sat_mac #(.ACC_W(ACC_W)) u_cell (
                    .clk     (clk),
                    .rst     (rst),
                    .clr_i   (w_clr),
                    .en_i    (w_mac_en),
                    .prod_i  (w_prod),
                    .acc_o   (w_acc[r*N + c]),
                    .clamp_o (w_clamp[r*N + c])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            bidx_q      <= '0;
            oidx_q      <= '0;
            mode_q      <= MODE_I4;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        a_q[bidx_q] <= in_data[7:4];
                        b_q[bidx_q] <= in_data[3:0];
                        // Mode is frozen and the sticky flag cleared only when a new tile opens.
                        if (first_q) begin
                            mode_q  <= mode;
                            first_q <= 1'b0;
                            ovf_q   <= 1'b0;
                        end
                        if (bidx_q == LAST_BYTE) begin
                            bidx_q  <= '0;
                            last_q  <= in_last;
                            state_q <= MAC;
                        end else begin
                            bidx_q <= bidx_q + 1'b1;
                        end
                    end
                end
                MAC: begin
                    ovf_q <= ovf_q | (|w_clamp);
                    if (last_q) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (oidx_q == LAST_OUT) begin
                            oidx_q      <= '0;
                            state_q     <= LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            first_q     <= 1'b1;
                        end else begin
                            oidx_q     <= oidx_q + 1'b1;
                            out_last_q <= (oidx_q == PENULT);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = w_acc[oidx_q];
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mxm_tile_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mxm_tile_engine
//  Purpose  : Directed self-checking bench for mxm_tile_engine (N=4; ACC_W 16 and 10).
//  Revision : 1.0
// ============================================================================
module tb_mxm_tile_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_last,  ovf;
    logic [15:0] out_data;
    logic        in_ready10, out_valid10, out_last10, ovf10;
    logic [9:0]  out_data10;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_tab [16];
    int cyc;

    always #5 clk = ~clk;

    mxm_tile_engine #(.N(4), .ACC_W(16)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .ovf(ovf)
    );

    mxm_tile_engine #(.N(4), .ACC_W(10)) u_dut10 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready10),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid10), .out_ready(out_ready),
        .out_data(out_data10), .out_last(out_last10), .ovf(ovf10)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Four bytes per K step; in_last is driven inverted on bytes 0..2 to show it is ignored there.
    task automatic send_step(input logic [31:0] v, input bit lst, input bit m_after, input bit ovf_chk);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[31-8*i -: 8];
            in_last  = (i == 3) ? lst : ~lst;
            chk("load_in_ready", in_ready, 1);
            @(posedge clk); #1;
            if (i == 0) begin
                if (m_after) mode = 1'b1;
                if (ovf_chk) chk("ovf_clear_first_byte", ovf10, 0);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("mac_in_ready", in_ready, 0);
        chk("mac_out_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int n, input bit bp, input bit use10, input int exp10, output int cycles);
        cycles = 0;
        for (int k = 0; k < n; k++) begin
            if (bp) begin
                out_ready = 1'b0;
                chk($sformatf("hold_valid[%0d]", k), out_valid, 1);
                chk($sformatf("hold_data[%0d]", k), $signed(out_data), exp_tab[k]);
                @(posedge clk); #1;
                cycles++;
            end
            out_ready = 1'b1;
            chk($sformatf("out_valid[%0d]", k), out_valid, 1);
            chk($sformatf("out_data[%0d]", k), $signed(out_data), exp_tab[k]);
            chk($sformatf("out_last[%0d]", k), out_last, (k == 15) ? 1 : 0);
            if (use10) begin
                chk($sformatf("out_valid10[%0d]", k), out_valid10, 1);
                chk($sformatf("out_data10[%0d]", k), $signed(out_data10), exp10);
                chk($sformatf("out_last10[%0d]", k), out_last10, (k == 15) ? 1 : 0);
            end
            @(posedge clk); #1;
            cycles++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_ovf", ovf, 0);

        // int4, single K step: C[r][c] = (r+1) * 1
        send_step(32'h11213141, 1'b1, 1'b0, 1'b0);
        exp_tab = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 4,4,4,4};
        drain(16, 1'b0, 1'b0, 0, cyc);
        chk("t1_drain_cycles", cyc, 16);
        chk("t1_done_valid", out_valid, 0);
        chk("t1_done_in_ready", in_ready, 1);
        chk("t1_ovf", ovf, 0);

        // fp4: 6.0 * -6.0 = -36.0 -> -144 at LSB 0.25
        mode = 1'b1;
        send_step(32'h7F7F7F7F, 1'b1, 1'b0, 1'b0);
        exp_tab = '{-144,-144,-144,-144, -144,-144,-144,-144, -144,-144,-144,-144, -144,-144,-144,-144};
        drain(16, 1'b0, 1'b0, 0, cyc);
        chk("fp4_ovf", ovf, 0);

        // Backpressure: a=[1,3,5,7], b=[2,4,6,-8]
        mode = 1'b0;
        send_step(32'h12345678, 1'b1, 1'b0, 1'b0);
        exp_tab = '{2,4,6,-8, 6,12,18,-24, 10,20,30,-40, 14,28,42,-56};
        drain(16, 1'b1, 1'b0, 0, cyc);
        chk("bp_drain_cycles", cyc, 32);
        chk("bp_done_valid", out_valid, 0);

        // Saturation: 8 steps of -8*-8 = 64 -> 512 (16-bit) and clamp to 511 (10-bit)
        for (int s = 0; s < 7; s++) send_step(32'h88888888, 1'b0, 1'b0, 1'b0);
        send_step(32'h88888888, 1'b1, 1'b0, 1'b0);
        exp_tab = '{512,512,512,512, 512,512,512,512, 512,512,512,512, 512,512,512,512};
        chk("sat_ovf10_in_drain", ovf10, 1);
        drain(16, 1'b0, 1'b1, 511, cyc);
        chk("sat_ovf10_after_drain", ovf10, 1);
        chk("sat_ovf16", ovf, 0);

        // Next tile clears ovf on its first byte; reset pulse after the 5th result
        send_step(32'h11213141, 1'b1, 1'b0, 1'b1);
        exp_tab = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 4,4,4,4};
        drain(5, 1'b0, 1'b0, 0, cyc);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_in_ready10", in_ready10, 1);
        chk("rst_mid_out_last", out_last, 0);
        chk("rst_mid_out_data", $signed(out_data), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_step(32'h11213141, 1'b1, 1'b0, 1'b0);
        drain(16, 1'b0, 1'b0, 0, cyc);

        // mode flipped after byte 0 must keep int4: a=[7,1,-8,-2], b=[-1,2,3,4]
        mode = 1'b0;
        send_step(32'h7F1283E4, 1'b1, 1'b1, 1'b0);
        exp_tab = '{-7,14,21,28, -1,2,3,4, 8,-16,-24,-32, 2,-4,-6,-8};
        drain(16, 1'b0, 1'b0, 0, cyc);
        chk("flip_done_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
